// File: rtl/codificador_seletor.sv
// Selector code finder: walks candidate codes 0..63 in ascending order and
// returns the lowest CODE whose selector terminals match the requested levels.
module codificador_seletor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       t1_req,
  input  logic       t2_req,
  input  logic       ack,
  output logic [5:0] code,
  output logic       valid,
  output logic       busy,
  output logic       t1_out,
  output logic       t2_out,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [5:0] cnt_r, cnt_s;
  logic       t1_tgt_r, t1_tgt_s;
  logic       t2_tgt_r, t2_tgt_s;
  logic [5:0] code_r, code_s;
  logic       valid_r, valid_s;
  logic       busy_r, busy_s;
  logic       t1_out_r, t1_out_s;
  logic       t2_out_r, t2_out_s;
  logic       err_r, err_s;
  logic [1:0] eval_s;

  // Selector network, code bits 5..0 = A..F; returns {T1, T2}
  function automatic logic [1:0] sel_eval(input logic [5:0] c);
    logic a, b, cc, d, e, f;
    {a, b, cc, d, e, f} = c;
    sel_eval = {(~a & ~b), ((~d & ~f) | (~cc & e) | (~cc & d))};
  endfunction

  assign eval_s = sel_eval(cnt_r);

  // Next-state and next-output decode; every register holds unless changed
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    t1_tgt_s = t1_tgt_r;
    t2_tgt_s = t2_tgt_r;
    code_s   = code_r;
    valid_s  = valid_r;
    busy_s   = busy_r;
    t1_out_s = t1_out_r;
    t2_out_s = t2_out_r;
    err_s    = err_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_s  = SCAN;
          cnt_s    = 6'd0;
          t1_tgt_s = t1_req;
          t2_tgt_s = t2_req;
          busy_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (eval_s == {t1_tgt_r, t2_tgt_r}) begin
          code_s   = cnt_r;
          t1_out_s = eval_s[1];
          t2_out_s = eval_s[0];
          valid_s  = 1'b1;
          state_s  = DONE;
        end else if (cnt_r != 6'd63) begin
          cnt_s = cnt_r + 6'd1;
        end else begin
          // exhausted without a hit: counter stays at 63, no wrap
          err_s   = 1'b1;
          valid_s = 1'b0;
          code_s  = 6'd0;
          state_s = DONE;
        end
      end
      DONE: begin
        if (ack) begin
          valid_s = 1'b0;
          err_s   = 1'b0;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 6'd0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        err_s   = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 6'd0;
      t1_tgt_r <= 1'b0;
      t2_tgt_r <= 1'b0;
      code_r   <= 6'd0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      t1_out_r <= 1'b0;
      t2_out_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      t1_tgt_r <= t1_tgt_s;
      t2_tgt_r <= t2_tgt_s;
      code_r   <= code_s;
      valid_r  <= valid_s;
      busy_r   <= busy_s;
      t1_out_r <= t1_out_s;
      t2_out_r <= t2_out_s;
      err_r    <= err_s;
    end
  end

  assign code   = code_r;
  assign valid  = valid_r;
  assign busy   = busy_r;
  assign t1_out = t1_out_r;
  assign t2_out = t2_out_r;
  assign err    = err_r;

endmodule

// File: tb/tb_codificador_seletor.sv
// Bench for codificador_seletor: directed vector table, randomized
// transactions against a search-based reference, and reset corner cases.
module tb_codificador_seletor;

  logic       clk = 1'b0;
  logic       rst_n, req, t1_req, t2_req, ack;
  logic [5:0] code;
  logic       valid, busy, t1_out, t2_out, err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  codificador_seletor dut (
    .clk(clk), .rst_n(rst_n), .req(req), .t1_req(t1_req), .t2_req(t2_req),
    .ack(ack), .code(code), .valid(valid), .busy(busy),
    .t1_out(t1_out), .t2_out(t2_out), .err(err)
  );

  typedef struct {
    logic t1;
    logic t2;
    int   exp_code;
    logic exp_t1;
    logic exp_t2;
    int   exp_edge;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Terminal levels of a candidate, taken digit by digit from its binary value
  function automatic logic [1:0] decode(input int k);
    int a, b, c, d, e, f;
    logic t1, t2;
    a = (k / 32) % 2; b = (k / 16) % 2; c = (k / 8) % 2;
    d = (k / 4) % 2;  e = (k / 2) % 2;  f = k % 2;
    t1 = (a == 0) && (b == 0);
    t2 = ((d == 0) && (f == 0)) || ((c == 0) && (e == 1)) || ((c == 0) && (d == 1));
    return {t1, t2};
  endfunction

  function automatic int ref_code(input logic t1, input logic t2);
    for (int k = 0; k < 64; k++)
      if (decode(k) == {t1, t2}) return k;
    return -1;
  endfunction

  // One full request/scan/hold/ack transaction; starts and ends at a negedge
  task automatic run_txn(input logic t1, input logic t2, input int exp_code,
                         input logic exp_t1, input logic exp_t2, input int exp_edge,
                         input bit noisy);
    int  edge_n;
    bit  seen;
    int  hold;
    logic [8:0] snap;
    req = 1'b1; t1_req = t1; t2_req = t2; ack = 1'b0;
    @(posedge clk);
    edge_n = 1;
    #1 req = 1'b0;
    @(negedge clk);
    chk("busy_after_req", busy, 1);
    chk("valid_after_req", valid, 0);
    seen = 1'b0;
    while (!seen && edge_n < 80) begin
      if (noisy) begin
        t1_req = 1'($urandom); t2_req = 1'($urandom);
        req = 1'($urandom);    ack = 1'($urandom);
      end
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      if (valid || err) seen = 1'b1;
    end
    req = 1'b0; ack = 1'b0;
    chk("result_timeout", seen, 1);
    chk("latency_edge", edge_n, exp_edge);
    chk("code", code, exp_code);
    chk("t1_out", t1_out, exp_t1);
    chk("t2_out", t2_out, exp_t2);
    chk("redecode", decode(int'(code)), {t1, t2});
    chk("err", err, 0);
    chk("busy_done", busy, 1);
    // hold in DONE with REQ toggling: nothing may move
    snap = {code, valid, busy, err};
    hold = noisy ? int'($urandom_range(1, 10)) : 10;
    for (int i = 0; i < hold; i++) begin
      req = ~req;
      t1_req = 1'($urandom); t2_req = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("done_hold", {code, valid, busy, err}, snap);
    end
    // ACK together with REQ: REQ must not be queued
    ack = 1'b1; req = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("ack_valid", valid, 0);
    chk("ack_busy", busy, 0);
    chk("ack_code_hold", code, exp_code);
    @(posedge clk);
    @(negedge clk);
    chk("no_queued_req", busy, 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 0,  1'b1, 1'b1, 2};
    vecs[1] = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 3};
    vecs[2] = '{1'b0, 1'b1, 16, 1'b0, 1'b1, 18};
    vecs[3] = '{1'b0, 1'b0, 17, 1'b0, 1'b0, 19};

    rst_n = 1'b0; req = 1'b0; t1_req = 1'b0; t2_req = 1'b0; ack = 1'b0;
    #12;
    chk("reset_outputs", {code, valid, busy, t1_out, t2_out, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // ACK in IDLE must be ignored
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    chk("idle_ack_ignored", {code, valid, busy, err}, 0);

    foreach (vecs[i])
      run_txn(vecs[i].t1, vecs[i].t2, vecs[i].exp_code, vecs[i].exp_t1,
              vecs[i].exp_t2, vecs[i].exp_edge, 1'b0);

    for (int n = 0; n < 16; n++) begin
      logic t1, t2;
      int   k;
      logic [1:0] tv;
      t1 = 1'($urandom); t2 = 1'($urandom);
      k  = ref_code(t1, t2);
      tv = decode(k);
      run_txn(t1, t2, k, tv[1], tv[0], k + 2, 1'b1);
    end

    // asynchronous reset in the middle of a scan
    req = 1'b1; t1_req = 1'b0; t2_req = 1'b0;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {code, valid, busy, t1_out, t2_out, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 1'b0, 17, 1'b0, 1'b0, 19, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/codificador_seletor.md
CODIFICADOR_SELETOR -- requirements
Module: codificador_seletor

Interface
REQ-001 The block SHALL have the ports below, one clock domain, all registered outputs:
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ  input  1  start request, sampled only in IDLE.
REQ-005 T1_REQ  input  1  desired TERMINAL1 level, captured with REQ.
REQ-006 T2_REQ  input  1  desired TERMINAL2 level, captured with REQ.
REQ-007 ACK  input  1  consumer acknowledge of CODE, honoured only in DONE.
REQ-008 CODE  output  6  selector input code, bit5..bit0 = A,B,C,D,E,F.
REQ-009 VALID  output  1  CODE/T1_OUT/T2_OUT valid, held until ACK.
REQ-010 BUSY  output  1  high in SCAN and DONE.
REQ-011 T1_OUT  output  1  TERMINAL1 produced by CODE, for self-check.
REQ-012 T2_OUT  output  1  TERMINAL2 produced by CODE, for self-check.
REQ-013 ERR  output  1  no code found for captured targets, held until ACK.

Function
REQ-014 Selector function SHALL be T1 = ~A & ~B; T2 = (~D & ~F) | (~C & E) | (~C & D).
REQ-015 FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-016 IDLE: REQ=1 at an edge -> capture T1_REQ/T2_REQ, clear 6-bit counter CNT to 0, go SCAN.
REQ-017 IDLE: REQ=0 -> stay IDLE; outputs held at reset values.
REQ-018 SCAN: each edge evaluates REQ-014 on CNT; one candidate per clock, ascending from 0.
REQ-019 SCAN match (T1==captured T1, T2==captured T2) -> CODE<=CNT, T1_OUT/T2_OUT<=evaluated values, VALID<=1, go DONE.
REQ-020 SCAN no match, CNT<63 -> CNT<=CNT+1, stay SCAN.
REQ-021 SCAN no match at CNT=63 -> ERR<=1, VALID<=0, CODE<=0, go DONE; CNT SHALL NOT wrap.
REQ-022 Result SHALL be the lowest matching code.
REQ-023 Latency: for result code k, VALID SHALL rise at the (k+2)th rising edge counting the REQ-sampling edge as 1st.
REQ-024 DONE: ACK=1 at an edge -> VALID<=0, ERR<=0, go IDLE; CODE, T1_OUT, T2_OUT hold last values.
REQ-025 DONE: ACK=0 -> all outputs held stable.
REQ-026 REQ in SCAN or DONE SHALL be ignored and not queued, including REQ and ACK in the same DONE cycle.
REQ-027 ACK outside DONE SHALL be ignored.
REQ-028 T1_REQ/T2_REQ changes after capture SHALL NOT affect an in-progress scan.
REQ-029 BUSY SHALL be 1 in SCAN and DONE, 0 in IDLE; a new REQ is accepted no earlier than the edge after ACK.

Reset
REQ-030 RST_N=0 SHALL immediately, without a clock, force IDLE, CNT=0, CODE=0, VALID=0, BUSY=0, T1_OUT=0, T2_OUT=0, ERR=0.
REQ-031 Reset in SCAN or DONE SHALL abort the operation; no VALID pulse is produced for it.
REQ-032 After RST_N returns high, the first edge SHALL behave as IDLE.

Verification
REQ-033 REQ with T1_REQ=1,T2_REQ=1 -> CODE=6'b000000, T1_OUT=1, T2_OUT=1, VALID at edge 2.
REQ-034 REQ with T1_REQ=1,T2_REQ=0 -> CODE=6'b000001 (F=1), T1_OUT=1, T2_OUT=0, VALID at edge 3.
REQ-035 REQ with T1_REQ=0,T2_REQ=1 -> CODE=6'b010000 (B=1), VALID at edge 18; then T1_REQ=0,T2_REQ=0 -> CODE=6'b010001, VALID at edge 19.
REQ-036 Hold ACK=0 for 10 cycles in DONE with REQ toggling -> CODE/VALID stable, no new capture; ACK=1 -> VALID=0, BUSY=0 next edge.
REQ-037 Assert RST_N=0 mid-SCAN (T1_REQ=0,T2_REQ=0, after 8 edges) -> all outputs 0 asynchronously; next REQ restarts scan from CNT=0.
REQ-038 Exhaustive check: every target pair's CODE re-decoded by REQ-014 equals the targets; ERR remains 0 for all four pairs.
